// File: rtl/ascon_inv_sbox_layer.sv
// ============================================================================
// Module      : ascon_inv_sbox_layer
// Description : Iterative inverse Ascon S-box layer over a 320-bit state,
//               LANES columns per cycle, valid/ready on input and output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ascon_inv_sbox_layer #(
    parameter int LANES = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [319:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [319:0] out_state,
    output logic         busy
);

    localparam int         NCYC       = 64 / LANES;
    localparam logic [6:0] C_STEP     = 7'(LANES);
    localparam logic [5:0] C_LAST_COL = 6'((NCYC - 1) * LANES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [319:0]   r_data;
    logic [5:0]     r_col;
    logic           w_last;
    logic [63:0]    w_x   [5];
    logic [63:0]    w_nx  [5];
    logic [4:0]     w_sub [LANES];
    logic [5:0]     w_idx [LANES];
    logic [319:0]   w_next;

    function automatic logic [4:0] inv_sbox(input logic [4:0] v);
        logic [4:0] r;
        case (v)
            5'd0:  r = 5'd20;  5'd1:  r = 5'd26;  5'd2:  r = 5'd7;   5'd3:  r = 5'd13;
            5'd4:  r = 5'd0;   5'd5:  r = 5'd9;   5'd6:  r = 5'd14;  5'd7:  r = 5'd18;
            5'd8:  r = 5'd10;  5'd9:  r = 5'd6;   5'd10: r = 5'd29;  5'd11: r = 5'd1;
            5'd12: r = 5'd25;  5'd13: r = 5'd21;  5'd14: r = 5'd19;  5'd15: r = 5'd30;
            5'd16: r = 5'd24;  5'd17: r = 5'd22;  5'd18: r = 5'd11;  5'd19: r = 5'd17;
            5'd20: r = 5'd3;   5'd21: r = 5'd5;   5'd22: r = 5'd28;  5'd23: r = 5'd31;
            5'd24: r = 5'd23;  5'd25: r = 5'd27;  5'd26: r = 5'd4;   5'd27: r = 5'd8;
            5'd28: r = 5'd15;  5'd29: r = 5'd12;  5'd30: r = 5'd16;  default: r = 5'd2;
        endcase
        return r;
    endfunction

    assign w_x[0] = r_data[319:256];
    assign w_x[1] = r_data[255:192];
    assign w_x[2] = r_data[191:128];
    assign w_x[3] = r_data[127:64];
    assign w_x[4] = r_data[63:0];

    // Each lane reads one column of the current window; x0 supplies the MSB.
    generate
        for (genvar k = 0; k < LANES; k++) begin : g_lane
            logic [5:0] idx;
            logic [4:0] col_in;
            assign idx      = r_col + 6'(k);
            assign col_in   = {w_x[0][idx], w_x[1][idx], w_x[2][idx], w_x[3][idx], w_x[4][idx]};
            assign w_sub[k] = inv_sbox(col_in);
            assign w_idx[k] = idx;
        end
    endgenerate

    always_comb begin
        for (int i = 0; i < 5; i++) begin
            w_nx[i] = w_x[i];
        end
        for (int k = 0; k < LANES; k++) begin
            for (int i = 0; i < 5; i++) begin
                w_nx[i][w_idx[k]] = w_sub[k][4-i];
            end
        end
        w_next = {w_nx[0], w_nx[1], w_nx[2], w_nx[3], w_nx[4]};
    end

    // Terminal window is the one where col + LANES reaches 64.
    assign w_last = (r_col == C_LAST_COL);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (in_valid)  w_state_nxt = RUN;
            RUN:     if (w_last)    w_state_nxt = DONE;
            DONE:    if (out_ready) w_state_nxt = IDLE;
            default:                w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_data <= '0;
            r_col  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_data <= in_state;
                        r_col  <= '0;
                    end
                end
                RUN: begin
                    r_data <= w_next;
                    r_col  <= w_last ? 6'd0 : r_col + C_STEP[5:0];
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state != IDLE);
    assign out_state = out_valid ? r_data : '0;

endmodule

`default_nettype wire

// File: tb/tb_ascon_inv_sbox_layer.sv
// ============================================================================
// Module      : tb_ascon_inv_sbox_layer
// Description : Scoreboard bench for three inverse S-box layers (LANES 1/8/64).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ascon_inv_sbox_layer;

    localparam int NDUT = 3;
    localparam int LV [NDUT] = '{1, 8, 64};
    localparam logic [4:0] SB [32] = '{
        5'd4,  5'd11, 5'd31, 5'd20, 5'd26, 5'd21, 5'd9,  5'd2,
        5'd27, 5'd5,  5'd8,  5'd18, 5'd29, 5'd3,  5'd6,  5'd28,
        5'd30, 5'd19, 5'd7,  5'd14, 5'd0,  5'd13, 5'd17, 5'd24,
        5'd16, 5'd12, 5'd1,  5'd25, 5'd22, 5'd10, 5'd15, 5'd23};
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [319:0] in_state = '0;
    logic [319:0] exp_cur = '0;

    logic         in_ready_a  [NDUT];
    logic         out_valid_a [NDUT];
    logic         busy_a      [NDUT];
    logic [319:0] out_state_a [NDUT];

    logic [319:0] q [NDUT][$];
    int           done_cnt [NDUT];
    int           n_checks = 0;
    int           n_errors = 0;

    always #5 clk = ~clk;

    generate
        for (genvar i = 0; i < NDUT; i++) begin : g_dut
            ascon_inv_sbox_layer #(.LANES(LV[i])) u_dut (
                .clk       (clk),
                .rst_n     (rst_n),
                .in_valid  (in_valid),
                .in_ready  (in_ready_a[i]),
                .in_state  (in_state),
                .out_valid (out_valid_a[i]),
                .out_ready (out_ready),
                .out_state (out_state_a[i]),
                .busy      (busy_a[i])
            );
        end
    endgenerate

    task automatic check_eq(input string tag, input logic [319:0] got, input logic [319:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [319:0] fwd_sbox(input logic [319:0] x);
        logic [319:0] r;
        logic [4:0]   v;
        r = '0;
        for (int j = 0; j < 64; j++) begin
            v = {x[256+j], x[192+j], x[128+j], x[64+j], x[j]};
            v = SB[v];
            r[256+j] = v[4]; r[192+j] = v[3]; r[128+j] = v[2]; r[64+j] = v[1]; r[j] = v[0];
        end
        return r;
    endfunction

    function automatic logic [319:0] rand_state();
        logic [319:0] r;
        for (int i = 0; i < 10; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Scoreboard: push on input handshake, pop/compare on output handshake.
    always @(negedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NDUT; i++) q[i].delete();
        end else begin
            for (int i = 0; i < NDUT; i++) begin
                if (in_valid && in_ready_a[i]) q[i].push_back(exp_cur);
                if (out_valid_a[i] && out_ready) begin
                    if (q[i].size() == 0) begin
                        check_eq($sformatf("orphan_out_L%0d", LV[i]), 320'd0, 320'd1);
                    end else begin
                        check_eq($sformatf("out_L%0d", LV[i]), out_state_a[i], q[i].pop_front());
                        done_cnt[i]++;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (!(in_ready_a[0] && in_ready_a[1] && in_ready_a[2]) && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) check_eq("idle_timeout", 320'(n), 320'd0);
    endtask

    task automatic run_one(input logic [319:0] din, input logic [319:0] dexp, input string tag);
        int n;
        wait_idle();
        in_state = din;
        exp_cur  = dexp;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid_a[1] && n < 30) begin
            tick();
            n++;
        end
        check_eq({tag, "_state"}, out_state_a[1], dexp);
        tick();
        wait_idle();
    endtask

    initial begin
        logic [319:0] x;
        int n;
        int base [NDUT];
        for (int i = 0; i < NDUT; i++) done_cnt[i] = 0;

        // Reset state
        rst_n = 1'b0;
        tick();
        tick();
        check_eq("rst_in_ready",  320'(in_ready_a[1]),  320'd1);
        check_eq("rst_out_valid", 320'(out_valid_a[1]), 320'd0);
        check_eq("rst_busy",      320'(busy_a[1]),      320'd0);
        check_eq("rst_out_state", out_state_a[1],       320'd0);
        rst_n = 1'b1;
        tick();

        // Zero state: latency and busy window
        in_state  = '0;
        exp_cur   = {ONES, 64'd0, ONES, 64'd0, 64'd0};
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid_a[1] && n < 20) begin
            check_eq("zero_busy", 320'(busy_a[1]), 320'd1);
            tick();
            n++;
        end
        check_eq("zero_latency", 320'(n), 320'd8);
        check_eq("zero_busy_done", 320'(busy_a[1]), 320'd1);
        check_eq("zero_state", out_state_a[1], {ONES, 64'd0, ONES, 64'd0, 64'd0});
        tick();
        check_eq("zero_post_valid", 320'(out_valid_a[1]), 320'd0);
        check_eq("zero_post_ready", 320'(in_ready_a[1]),  320'd1);
        check_eq("zero_post_busy",  320'(busy_a[1]),      320'd0);

        run_one({320{1'b1}}, {64'd0, 64'd0, 64'd0, ONES, 64'd0}, "ones");
        run_one({64'd0, 64'd0, 64'd1, 64'd0, 64'd0},
                {ONES - 64'd1, 64'd0, ONES - 64'd1, 64'd0, 64'd0}, "col0");

        // Backpressure in DONE
        wait_idle();
        x         = rand_state();
        in_state  = fwd_sbox(x);
        exp_cur   = x;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid_a[1] && n < 30) begin
            tick();
            n++;
        end
        for (int c = 0; c < 20; c++) begin
            check_eq("bp_valid", 320'(out_valid_a[1]), 320'd1);
            check_eq("bp_state", out_state_a[1], x);
            check_eq("bp_in_ready", 320'(in_ready_a[1]), 320'd0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        check_eq("bp_release_ready", 320'(in_ready_a[1]),  320'd1);
        check_eq("bp_release_valid", 320'(out_valid_a[1]), 320'd0);

        // Reset on the 4th RUN edge
        wait_idle();
        x        = rand_state();
        in_state = fwd_sbox(x);
        exp_cur  = x;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_eq("mid_rst_valid", 320'(out_valid_a[1]), 320'd0);
        check_eq("mid_rst_state", out_state_a[1],       320'd0);
        check_eq("mid_rst_busy",  320'(busy_a[1]),      320'd0);
        check_eq("mid_rst_ready", 320'(in_ready_a[1]),  320'd1);
        x = rand_state();
        run_one(fwd_sbox(x), x, "post_rst");

        // Random round trip with random handshakes on all three widths
        for (int i = 0; i < NDUT; i++) base[i] = done_cnt[i];
        n = 0;
        while (done_cnt[1] - base[1] < 1000 && n < 40000) begin
            x         = rand_state();
            in_state  = fwd_sbox(x);
            exp_cur   = x;
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
            n++;
        end
        check_eq("rand_count_L8", 320'(done_cnt[1] - base[1] >= 1000), 320'd1);
        check_eq("rand_any_L1",   320'(done_cnt[0] - base[0] > 0),     320'd1);
        check_eq("rand_any_L64",  320'(done_cnt[2] - base[2] > 0),     320'd1);
        wait_idle();
        tick();
        for (int i = 0; i < NDUT; i++) begin
            check_eq($sformatf("lost_L%0d", LV[i]), 320'(q[i].size()), 320'd0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
